// File: rtl/zuma_lut_pkg.sv
// Shared types and sizing helpers for the ZUMA LUT bank.
// Loader FSM states plus bit-count and counter-width helpers.
package zuma_lut_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } cfg_state_t;

    function automatic int total_bits(input int num_luts,
                                      input int lut_size);
        return num_luts << lut_size;
    endfunction

    // One spare bit so the counter can represent "one past the last bit".
    function automatic int cnt_width(input int num_luts,
                                     input int lut_size);
        return $clog2(total_bits(num_luts, lut_size)) + 1;
    endfunction

    localparam int CNT_W = cnt_width(8, 6);

endpackage

// File: rtl/zuma_lutram_1b.sv
// Behavioural 2^K x 1 LUTRAM: synchronous write, asynchronous read.
// Replaced per platform by the vendor distributed-RAM primitive.
module zuma_lutram_1b #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] a,
    input  logic              d,
    input  logic              we,
    input  logic [ADDR_W-1:0] dpra,
    output logic              dpo
);

    logic mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
    end

    assign dpo = mem[dpra];

endmodule

// File: rtl/zuma_lut_bank.sv
// Bank of K-input LUTs on 1-bit LUTRAM with a serial config loader.
// Outputs stay gated to 0 until a complete load has finished.
module zuma_lut_bank
    import zuma_lut_pkg::*;
#(
    parameter int LUT_SIZE  = 6,
    parameter int NUM_LUTS  = 8,
    parameter int CFG_WIDTH = 8,
    parameter int REG_OUT   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LUTS*LUT_SIZE-1:0] lut_in,
    output logic [NUM_LUTS-1:0]          lut_out,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [CFG_WIDTH-1:0]         cfg_data,
    output logic                         cfg_busy,
    output logic                         cfg_done
);

    localparam int TOTAL = total_bits(NUM_LUTS, LUT_SIZE);
    localparam int CW    = cnt_width(NUM_LUTS, LUT_SIZE);
    localparam int WCW   = $clog2(CFG_WIDTH + 1);

    localparam logic [CW-1:0]  LAST  = CW'(TOTAL - 1);
    localparam logic [WCW-1:0] WLAST = WCW'(CFG_WIDTH - 1);

    cfg_state_t           state;
    logic [CW-1:0]        bit_cnt;
    logic [WCW-1:0]       wr_cnt;
    logic [CFG_WIDTH-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            wr_cnt    <= '0;
            shift_q   <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
        end else if (cfg_start) begin
            // Restart wins over a word offered in the same cycle.
            state     <= LOAD;
            bit_cnt   <= '0;
            wr_cnt    <= '0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        shift_q   <= cfg_data;
                        wr_cnt    <= '0;
                        state     <= WRITE;
                        cfg_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    shift_q <= shift_q >> 1;
                    bit_cnt <= bit_cnt + CW'(1);
                    wr_cnt  <= wr_cnt + WCW'(1);
                    if (wr_cnt == WLAST) begin
                        if (bit_cnt == LAST) begin
                            state    <= DONE;
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    logic [CW-1:0]       lut_idx;
    logic [LUT_SIZE-1:0] wr_addr;
    logic                wr_en;

    assign lut_idx = bit_cnt >> LUT_SIZE;
    assign wr_addr = bit_cnt[LUT_SIZE-1:0];
    assign wr_en   = (state == WRITE);

    logic [NUM_LUTS-1:0] rd_raw;
    logic [NUM_LUTS-1:0] rd_clean;
    logic [NUM_LUTS-1:0] rd_gated;

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic we_i;
        assign we_i = wr_en && (lut_idx == CW'(i));

        zuma_lutram_1b #(
            .ADDR_W (LUT_SIZE)
        ) u_ram (
            .clk  (clk),
            .a    (wr_addr),
            .d    (shift_q[0]),
            .we   (we_i),
            .dpra (lut_in[i*LUT_SIZE +: LUT_SIZE]),
            .dpo  (rd_raw[i])
        );
    end

    always_comb begin
        rd_clean = rd_raw;
`ifdef SIMULATION
        for (int i = 0; i < NUM_LUTS; i++) begin
            if ($isunknown(rd_raw[i])) begin
                rd_clean[i] = 1'b0;
            end
        end
`endif
    end

    assign rd_gated = cfg_done ? rd_clean : '0;

    if (REG_OUT != 0) begin : g_reg
        logic [NUM_LUTS-1:0] out_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                out_q <= '0;
            end else begin
                out_q <= rd_gated;
            end
        end

        assign lut_out = out_q;
    end else begin : g_comb
        assign lut_out = rd_gated;
    end

endmodule

// File: tb/tb_zuma_lut_bank.sv
// Directed bench for zuma_lut_bank: comb and registered-output copies
// share one stimulus stream.
module tb_zuma_lut_bank;

    localparam int K = 6;
    localparam int N = 8;
    localparam int W = 8;
    localparam int NWORDS = (N << K) / W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           cfg_start;
    logic           cfg_valid;
    logic [W-1:0]   cfg_data;
    logic [N*K-1:0] lut_in;

    logic [N-1:0] lut_out;
    logic         cfg_ready, cfg_busy, cfg_done;
    logic [N-1:0] lut_out_r;
    logic         cfg_ready_r, cfg_busy_r, cfg_done_r;

    zuma_lut_bank #(
        .LUT_SIZE (K), .NUM_LUTS (N), .CFG_WIDTH (W), .REG_OUT (0)
    ) dut (
        .clk (clk), .reset (reset), .lut_in (lut_in),
        .lut_out (lut_out), .cfg_start (cfg_start),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .cfg_data (cfg_data), .cfg_busy (cfg_busy),
        .cfg_done (cfg_done)
    );

    zuma_lut_bank #(
        .LUT_SIZE (K), .NUM_LUTS (N), .CFG_WIDTH (W), .REG_OUT (1)
    ) dut_r (
        .clk (clk), .reset (reset), .lut_in (lut_in),
        .lut_out (lut_out_r), .cfg_start (cfg_start),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready_r),
        .cfg_data (cfg_data), .cfg_busy (cfg_busy_r),
        .cfg_done (cfg_done_r)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    logic [63:0]    tt [N];
    logic [N*K-1:0] vecs [8];

    function automatic logic [N-1:0] tt_model(input logic [N*K-1:0] li);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = tt[i][li[i*K +: K]];
        return r;
    endfunction

    function automatic logic [N-1:0] xor_model(input logic [N*K-1:0] li);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ^li[i*K +: K];
        return r;
    endfunction

    task automatic send_word(input logic [W-1:0] d, output int acc);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        while (cfg_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (n >= 40) begin
            total++;
            $display("FAIL send_word: ready never rose, ready=%b", cfg_ready);
            cfg_valid = 1'b0;
        end else begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
    endtask

    task automatic load_all(input bit do_start, input int first_word,
                            input int stall_word, input int stall_len,
                            output int done_cyc);
        int acc, acc0, n;
        acc0 = cyc;
        if (do_start) begin
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
        end
        for (int w = first_word; w < NWORDS; w++) begin
            if (w == stall_word) begin
                n = 0;
                while (cfg_ready !== 1'b1 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                for (int s = 0; s < stall_len; s++) begin
                    total++;
                    if (cfg_ready !== 1'b1 || cfg_busy !== 1'b1)
                        $display("FAIL stall_hold: ready=%b busy=%b need 1 1",
                                 cfg_ready, cfg_busy);
                    else passed++;
                    @(negedge clk);
                end
            end
            send_word(tt[w/8][(w%8)*8 +: 8], acc);
            if (w == first_word) acc0 = acc;
        end
        n = 0;
        while (cfg_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            $display("FAIL load_done: cfg_done=%b never rose", cfg_done);
        end
        done_cyc = cyc - acc0;
    endtask

    task automatic check_reads(input string tag, input bit use_xor);
        logic [N-1:0] exp;
        for (int v = 0; v < 8; v++) begin
            lut_in = vecs[v];
            #1;
            exp = use_xor ? xor_model(lut_in) : tt_model(lut_in);
            total++;
            if (lut_out !== exp)
                $display("FAIL %s vec%0d: lut_out=%h need %h",
                         tag, v, lut_out, exp);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (lut_out !== 8'h00 || lut_out_r !== 8'h00)
            $display("FAIL reset_out: comb=%h reg=%h need 00 00",
                     lut_out, lut_out_r);
        else passed++;
        total++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b000 ||
            {cfg_ready_r, cfg_busy_r, cfg_done_r} !== 3'b000)
            $display("FAIL reset_flags: rbd=%b%b%b need 000",
                     cfg_ready, cfg_busy, cfg_done);
        else passed++;
        lut_in = '1;
        #1;
        total++;
        if (lut_out !== 8'h00)
            $display("FAIL reset_gate: lut_out=%h need 00", lut_out);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (lut_out !== 8'h00 || cfg_done !== 1'b0)
            $display("FAIL idle_gate: lut_out=%h done=%b need 00 0",
                     lut_out, cfg_done);
        else passed++;
    endtask

    task automatic test_full_load();
        int dc;
        for (int i = 0; i < N; i++) tt[i] = 64'h8000_0000_0000_0000;
        lut_in = '1;
        load_all(1'b1, 0, -1, 0, dc);
        total++;
        if (dc !== 576)
            $display("FAIL load_cycles: done at cycle %0d need 576", dc);
        else passed++;
        total++;
        if (lut_out !== 8'hFF || cfg_done_r !== 1'b1)
            $display("FAIL and_ones: lut_out=%h done_r=%b need FF 1",
                     lut_out, cfg_done_r);
        else passed++;
        total++;
        if (lut_out_r !== 8'h00)
            $display("FAIL reg_first: lut_out_r=%h need 00", lut_out_r);
        else passed++;
        total++;
        if (cfg_ready !== 1'b0 || cfg_busy !== 1'b0)
            $display("FAIL done_flags: ready=%b busy=%b need 0 0",
                     cfg_ready, cfg_busy);
        else passed++;
        @(negedge clk);
        total++;
        if (lut_out_r !== 8'hFF)
            $display("FAIL reg_second: lut_out_r=%h need FF", lut_out_r);
        else passed++;
        lut_in = '0;
        #1;
        total++;
        if (lut_out !== 8'h00)
            $display("FAIL and_zero: lut_out=%h need 00", lut_out);
        else passed++;
        @(negedge clk);
        check_reads("and_vec", 1'b0);
    endtask

    task automatic test_backpressure();
        int dc;
        logic [7:0] ib;
        for (int i = 0; i < N; i++) begin
            ib = 8'(i);
            tt[i] = 64'hC3A5_0F96_5A3C_E187 ^ {8{ib}};
        end
        load_all(1'b1, 0, 20, 5, dc);
        total++;
        if (dc !== 581)
            $display("FAIL stall_cycles: done at %0d need 581", dc);
        else passed++;
        check_reads("stall_vec", 1'b0);
    endtask

    task automatic test_restart();
        int dc, acc;
        logic [7:0] ib;
        for (int i = 0; i < N; i++) begin
            ib = 8'(i);
            tt[i] = 64'h0123_4567_89AB_CDEF ^ {8{ib}};
        end
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        total++;
        if ({cfg_done, cfg_ready, cfg_busy} !== 3'b011)
            $display("FAIL restart_clr: drb=%b%b%b need 011",
                     cfg_done, cfg_ready, cfg_busy);
        else passed++;
        for (int w = 0; w < 30; w++) send_word(tt[w/8][(w%8)*8 +: 8], acc);
        while (cfg_ready !== 1'b1 && acc < 40) begin
            @(negedge clk);
            acc++;
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        total++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b110)
            $display("FAIL start_vs_valid: rbd=%b%b%b need 110",
                     cfg_ready, cfg_busy, cfg_done);
        else passed++;
        for (int i = 0; i < N; i++) tt[i] = ~tt[i] ^ {i[7:0], 56'h0};
        load_all(1'b0, 0, -1, 0, dc);
        total++;
        if (dc !== 576)
            $display("FAIL restart_cycles: done at %0d need 576", dc);
        else passed++;
        check_reads("restart_vec", 1'b0);
    endtask

    task automatic test_reset_mid();
        int dc, acc;
        for (int i = 0; i < N; i++) tt[i] = 64'h6996_9669_9669_6996;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int w = 0; w < 10; w++) send_word(tt[w/8][(w%8)*8 +: 8], acc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lut_in = '1;
        #1;
        total++;
        if ({cfg_ready, cfg_busy, cfg_done} !== 3'b000 || lut_out !== 8'h00)
            $display("FAIL mid_reset: rbd=%b%b%b out=%h need 000 00",
                     cfg_ready, cfg_busy, cfg_done, lut_out);
        else passed++;
        @(negedge clk);
        load_all(1'b1, 0, -1, 0, dc);
        check_reads("xor_vec", 1'b1);
    endtask

    task automatic test_reg_out();
        logic [N*K-1:0] a_in, b_in;
        a_in = {8{6'b000011}};
        b_in = {8{6'b000001}};
        lut_in = a_in;
        @(negedge clk);
        total++;
        if (lut_out_r !== xor_model(a_in))
            $display("FAIL reg_a: lut_out_r=%h need %h",
                     lut_out_r, xor_model(a_in));
        else passed++;
        lut_in = b_in;
        #1;
        total++;
        if (lut_out_r !== 8'h00 || lut_out !== 8'hFF)
            $display("FAIL reg_hold: reg=%h comb=%h need 00 FF",
                     lut_out_r, lut_out);
        else passed++;
        @(negedge clk);
        total++;
        if (lut_out_r !== 8'hFF)
            $display("FAIL reg_b: lut_out_r=%h need FF", lut_out_r);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (lut_out_r !== 8'hFF)
            $display("FAIL reg_pre_rst: lut_out_r=%h need FF", lut_out_r);
        else passed++;
        @(negedge clk);
        total++;
        if (lut_out_r !== 8'h00)
            $display("FAIL reg_rst: lut_out_r=%h need 00", lut_out_r);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        lut_in    = '0;
        vecs[0] = '1;
        vecs[1] = '0;
        vecs[2] = 48'h5555_5555_5555;
        vecs[3] = 48'hAAAA_AAAA_AAAA;
        vecs[4] = 48'h0123_4567_89AB;
        vecs[5] = 48'hFEDC_BA98_7654;
        vecs[6] = 48'hFC0F_C0FC_0FC0;
        vecs[7] = 48'h1041_0410_4104;
        @(negedge clk);
        test_reset();
        test_full_load();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_reg_out();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
